wb_copy_master: RTL
===================

Name: wb_copy_master

Overview:
- Wishbone master that copies a block of 32-bit words from a source address to a destination address, one read then one write per word.
- Sits beside the CPU on the shared Wishbone bus. Drives on-chip block RAM slaves for memory init, buffer moves and fills.
- Control is a start pulse plus address/length inputs latched at start. Completion is a one-cycle done pulse.

Parameters:
- LEN_W, 16, width of word-count input; max transfer is 2^LEN_W-1 words.
- TIMEOUT, 255, cycles to wait for wb_ack_i before abort; used only with the optional feature.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle start request; sampled only in IDLE
- src_adr_i  in  32  source byte address; bits [1:0] ignored (word aligned)
- dst_adr_i  in  32  destination byte address; bits [1:0] ignored
- len_i  in  LEN_W  number of words to copy
- busy_o  out  1  high from cycle after accepted start until done pulse
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky abort flag, cleared on next accepted start
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  write data (the read-back word)
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte selects, constant 4'hF
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_we_o  out  1  write enable
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- Reset values: busy_o, done_o, err_o, wb_stb_o, wb_cyc_o, wb_we_o = 0; wb_adr_o, wb_dat_o = 0; state IDLE.
- Asserting rst_i mid-transfer drops cyc/stb/we immediately, with no done pulse.
- FSM states: IDLE, RD, RGAP, WR, WGAP, FIN.
- IDLE: on start_i, latch src, dst and len into internal registers; addresses are forced to word alignment. Clear err_o.
  - len=0 -> FIN.
  - Otherwise -> RD, with busy_o=1.
- RD: cyc=1, stb=1, we=0, adr=src.
  - Hold until wb_ack_i.
  - On ack: capture wb_dat_i into the data register, then -> RGAP.
- RGAP: stb=0, cyc stays 1, for exactly one cycle. This guarantees toggle-ack slaves see a fresh request. Then -> WR.
- WR: cyc=1, stb=1, we=1, adr=dst, dat=captured word, sel=4'hF.
  - On ack: src+=4, dst+=4, remaining-=1, then -> WGAP.
- WGAP: stb=0, we=0, for one cycle.
  - remaining=0 -> FIN, dropping cyc in the same cycle.
  - Otherwise -> RD.
- FIN: done_o=1 for one cycle, busy_o=0 from the next cycle, cyc=0, -> IDLE.
- Handshake: outputs stay stable while stb=1 and ack=0. wb_ack_i is ignored when stb=0.
- start_i while busy is ignored, with no queueing.
- Address arithmetic is modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- Overlapping regions are not detected; the copy is strictly ascending.
- Minimum cost is 4 clocks per word plus slave wait states. With a zero-wait slave: RD(1)+RGAP(1)+WR(1)+WGAP(1).

Optional Feature:
- Macro WB_COPY_TIMEOUT_EN.
- Defined: a counter runs while stb=1 and resets on ack or on stb=0.
  - Reaching TIMEOUT cycles without ack: drop cyc/stb/we, set err_o=1, -> FIN. done_o still pulses.
  - Remaining words are abandoned.
- Undefined: the master waits indefinitely for ack, err_o is tied to 0, and no counter logic exists.

Decomposition:
- Shared package holds the FSM state encoding, WB_SEL_ALL=4'hF and WORD_BYTES=4.
- One natural sub-module, wb_ack_timer, holds the timeout counter. It is instantiated only under WB_COPY_TIMEOUT_EN.

Test Plan:
- Preload bank A words 0..7 = 0x1000_0000+i; start src=0x0000, dst=0x1000, len=8 -> bank B words 0..7 match; done_o pulses once; busy_o low after it; 16 acks total.
- len=0, start -> done_o pulses within 2 cycles of start; wb_cyc_o never asserted.
- Slave inserting 3 wait states -> wb_adr_o, wb_dat_o and wb_we_o are stable across every stalled cycle; the data copy is still correct.
- src=0xFFFFFFF8, len=3 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert rst_i during the 3rd WR -> cyc/stb drop the same cycle; no done_o; the next start copies normally.
- With WB_COPY_TIMEOUT_EN, TIMEOUT=16, slave never acks -> stb drops after 16 cycles; err_o=1; done_o pulses; the next start clears err_o.

Source files
------------

// File: rtl/wb_copy_master_pkg.sv
// Shared types and constants for the Wishbone block-copy master.
// Holds the FSM encoding, the byte-select constant and the word stride.
package wb_copy_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RGAP,
        ST_WR,
        ST_WGAP,
        ST_FIN
    } state_t;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] wordAlign(input logic [31:0] adr);
        return {adr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_copy_master_if.sv
// Wishbone bus bundle between the copy master and its slave(s).
// Signal names follow the master's point of view.
interface wb_copy_master_if;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_we_o;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_we_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_we_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_copy_master_ack_timer.sv
// Acknowledge watchdog for the copy master; exists only when WB_COPY_TIMEOUT_EN is defined.
// Flags the last strobed cycle of a request that has waited TIMEOUT cycles without ack.
`ifdef WB_COPY_TIMEOUT_EN
module wb_ack_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_stb,
    input  logic i_ack,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (!i_stb || i_ack) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Firing on the TIMEOUT-th stalled cycle lets the FSM drop stb right after it.
    assign o_expired = i_stb && !i_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/wb_copy_master.sv
// Wishbone master copying len words from src to dst, one read then one write per word.
// Optional ack timeout abort is enabled by defining WB_COPY_TIMEOUT_EN.
module wb_copy_master
    import wb_copy_master_pkg::*;
#(
    parameter int LEN_W = 16
`ifdef WB_COPY_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_adr_i,
    input  logic [31:0]      dst_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    wb_copy_master_if.master wb
);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_rem;
    logic             w_start;
    logic             w_timeout;
    logic             w_cyc;
    logic             w_stb;
    logic             w_we;

    assign w_start = (r_state == ST_IDLE) && start_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_cyc  = 1'b0;
        w_stb  = 1'b0;
        w_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next = (len_i == '0) ? ST_FIN : ST_RD;
                end
            end
            ST_RD: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                if (w_timeout) begin
                    w_next = ST_FIN;
                end else if (wb.wb_ack_i) begin
                    w_next = ST_RGAP;
                end
            end
            ST_RGAP: begin
                w_cyc  = 1'b1;
                w_next = ST_WR;
            end
            ST_WR: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                w_we  = 1'b1;
                if (w_timeout) begin
                    w_next = ST_FIN;
                end else if (wb.wb_ack_i) begin
                    w_next = ST_WGAP;
                end
            end
            ST_WGAP: begin
                // The remaining count is already decremented here, so cyc can drop early.
                w_cyc  = (r_rem != '0);
                w_next = (r_rem == '0) ? ST_FIN : ST_RD;
            end
            ST_FIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_data <= '0;
            r_rem  <= '0;
        end else begin
            if (w_start) begin
                r_src <= wordAlign(src_adr_i);
                r_dst <= wordAlign(dst_adr_i);
                r_rem <= len_i;
            end
            if ((r_state == ST_RD) && wb.wb_ack_i) begin
                r_data <= wb.wb_dat_i;
            end
            if ((r_state == ST_WR) && wb.wb_ack_i) begin
                r_src <= r_src + WORD_BYTES;
                r_dst <= r_dst + WORD_BYTES;
                r_rem <= r_rem - LEN_W'(1);
            end
        end
    end

`ifdef WB_COPY_TIMEOUT_EN
    logic r_err;

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ackTimer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_stb     (w_stb),
        .i_ack     (wb.wb_ack_i),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_FIN);
    assign wb.wb_cyc_o = w_cyc;
    assign wb.wb_stb_o = w_stb;
    assign wb.wb_we_o  = w_we;
    assign wb.wb_adr_o = (r_state == ST_WR) ? r_dst : r_src;
    assign wb.wb_dat_o = r_data;
    assign wb.wb_sel_o = WB_SEL_ALL;

endmodule
